// File: rtl/fpm_pkg.sv
`default_nettype none
// ============================================================================
// Package     : fpm_pkg
// Description : Shared widths, types and the round-robin pick helper for the
//               floating-point multiplier arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
package fpm_pkg;

   localparam int FPM_WIDTH   = 32;
   localparam int FPM_LATENCY = 4;

   typedef logic [0:0]           fpm_id_t;
   typedef logic [FPM_WIDTH-1:0] fpm_word_t;

   // Winner between two requesters; a tie goes to the one not served last.
   function automatic fpm_id_t fpm_rr_pick(input logic v0, input logic v1,
                                           input fpm_id_t last);
      fpm_id_t pick;
      if (v0 && v1) begin
         pick = ~last;
      end else if (v1) begin
         pick = 1'b1;
      end else begin
         pick = 1'b0;
      end
      return pick;
   endfunction

endpackage
`default_nettype wire

// File: rtl/fpm_tag_pipe.sv
`default_nettype none
// ============================================================================
// Module      : fpm_tag_pipe
// Description : LATENCY-deep valid/owner shift register that moves in lockstep
//               with the multiplier stage registers (shared clock-enable).
// Revision    : 1.0 - initial release
// ============================================================================
module fpm_tag_pipe import fpm_pkg::*; #(
   parameter int LATENCY = FPM_LATENCY
) (
   input  logic    clk,
   input  logic    rst,
   input  logic    ce,
   input  logic    in_vld,
   input  fpm_id_t in_tag,
   output logic    out_vld,
   output fpm_id_t out_tag,
   output logic    any_vld
);

   logic    [LATENCY-1:0] vld_q, vld_d;
   fpm_id_t [LATENCY-1:0] tag_q, tag_d;

   // Shift one stage per enabled cycle, hold everything while stalled.
   always_comb begin
      vld_d = vld_q;
      tag_d = tag_q;
      if (ce) begin
         vld_d[0] = in_vld;
         tag_d[0] = in_tag;
         for (int i = 1; i < LATENCY; i++) begin
            vld_d[i] = vld_q[i-1];
            tag_d[i] = tag_q[i-1];
         end
      end
   end

   // Stage registers; reset drops every in-flight entry.
   always_ff @(posedge clk) begin
      if (rst) begin
         vld_q <= '0;
         tag_q <= '0;
      end else begin
         vld_q <= vld_d;
         tag_q <= tag_d;
      end
   end

   assign out_vld = vld_q[LATENCY-1];
   assign out_tag = tag_q[LATENCY-1];
   assign any_vld = |vld_q;

endmodule
`default_nettype wire

// File: rtl/fpm_mul_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : fpm_mul_arbiter
// Description : Round-robin sharing of one fixed-latency FP multiplier between
//               two requesters, with owner tracking and whole-pipe stall.
// Revision    : 1.0 - initial release
// ============================================================================
module fpm_mul_arbiter import fpm_pkg::*; #(
   parameter int WIDTH   = FPM_WIDTH,
   parameter int LATENCY = FPM_LATENCY
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             req0_valid,
   input  logic [WIDTH-1:0] req0_a,
   input  logic [WIDTH-1:0] req0_b,
   output logic             req0_ready,
   input  logic             req1_valid,
   input  logic [WIDTH-1:0] req1_a,
   input  logic [WIDTH-1:0] req1_b,
   output logic             req1_ready,
   output logic [WIDTH-1:0] mul_a,
   output logic [WIDTH-1:0] mul_b,
   output logic             mul_ce,
   input  logic [WIDTH-1:0] mul_y,
   input  logic             res_ready,
   output logic             res_valid,
   output logic             res_id,
   output logic [WIDTH-1:0] res_y,
   output logic             busy
);

   fpm_id_t          last_q, last_d;
   logic [WIDTH-1:0] mul_a_q, mul_a_d;
   logic [WIDTH-1:0] mul_b_q, mul_b_d;
   logic             iss_vld_q, iss_vld_d;
   fpm_id_t          iss_tag_q, iss_tag_d;
   logic             gnt_vld;
   fpm_id_t          gnt_id;
   logic             pipe_vld;
   fpm_id_t          pipe_tag;
   logic             pipe_any;

   // Stall the whole pipe only when a valid result is blocked; never in reset.
   always_comb begin
      mul_ce = 1'b1;
      if (!rst && pipe_vld && !res_ready) begin
         mul_ce = 1'b0;
      end
   end

   // Round-robin grant, suppressed while stalled or in reset.
   always_comb begin
      gnt_vld = 1'b0;
      gnt_id  = '0;
      if (!rst && mul_ce && (req0_valid || req1_valid)) begin
         gnt_vld = 1'b1;
         gnt_id  = fpm_rr_pick(req0_valid, req1_valid, last_q);
      end
   end

   assign req0_ready = gnt_vld && (gnt_id == 1'b0);
   assign req1_ready = gnt_vld && (gnt_id == 1'b1);

   // Issue register next state: operands and owner of the granted pair.
   always_comb begin
      last_d    = last_q;
      mul_a_d   = mul_a_q;
      mul_b_d   = mul_b_q;
      iss_vld_d = iss_vld_q;
      iss_tag_d = iss_tag_q;
      if (mul_ce) begin
         iss_vld_d = gnt_vld;
         if (gnt_vld) begin
            iss_tag_d = gnt_id;
            last_d    = gnt_id;
            mul_a_d   = (gnt_id == 1'b1) ? req1_a : req0_a;
            mul_b_d   = (gnt_id == 1'b1) ? req1_b : req0_b;
         end
      end
   end

   // Issue registers; last starts at 1 so requester 0 wins the first tie.
   always_ff @(posedge clk) begin
      if (rst) begin
         last_q    <= 1'b1;
         mul_a_q   <= '0;
         mul_b_q   <= '0;
         iss_vld_q <= 1'b0;
         iss_tag_q <= '0;
      end else begin
         last_q    <= last_d;
         mul_a_q   <= mul_a_d;
         mul_b_q   <= mul_b_d;
         iss_vld_q <= iss_vld_d;
         iss_tag_q <= iss_tag_d;
      end
   end

   // Owner tracking for the LATENCY multiplier stages behind the issue register.
   fpm_tag_pipe #(
      .LATENCY (LATENCY)
   ) u_tag_pipe (
      .clk     (clk),
      .rst     (rst),
      .ce      (mul_ce),
      .in_vld  (iss_vld_q),
      .in_tag  (iss_tag_q),
      .out_vld (pipe_vld),
      .out_tag (pipe_tag),
      .any_vld (pipe_any)
   );

   assign mul_a     = mul_a_q;
   assign mul_b     = mul_b_q;
   assign res_valid = pipe_vld;
   assign res_id    = pipe_tag;
   assign res_y     = mul_y;
   assign busy      = iss_vld_q | pipe_any;

endmodule
`default_nettype wire

// File: tb/tb_fpm_mul_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_fpm_mul_arbiter
// Description : Self-checking bench for fpm_mul_arbiter (LATENCY=4 and 1).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fpm_mul_arbiter;

   logic        clk = 1'b0;
   logic        rst;
   logic        req0_valid, req1_valid, req0_ready, req1_ready;
   logic [31:0] req0_a, req0_b, req1_a, req1_b;
   logic [31:0] mul_a, mul_b, mul_y, res_y;
   logic        mul_ce, res_ready, res_valid, res_id, busy;

   logic        d1_req0_valid, d1_req1_valid, d1_req0_ready, d1_req1_ready;
   logic [31:0] d1_req0_a, d1_req0_b, d1_req1_a, d1_req1_b;
   logic [31:0] d1_mul_a, d1_mul_b, d1_mul_y, d1_res_y;
   logic        d1_mul_ce, d1_res_ready, d1_res_valid, d1_res_id, d1_busy;

   always #5 clk = ~clk;

   fpm_mul_arbiter #(.WIDTH(32), .LATENCY(4)) dut (
      .clk(clk), .rst(rst),
      .req0_valid(req0_valid), .req0_a(req0_a), .req0_b(req0_b), .req0_ready(req0_ready),
      .req1_valid(req1_valid), .req1_a(req1_a), .req1_b(req1_b), .req1_ready(req1_ready),
      .mul_a(mul_a), .mul_b(mul_b), .mul_ce(mul_ce), .mul_y(mul_y),
      .res_ready(res_ready), .res_valid(res_valid), .res_id(res_id), .res_y(res_y),
      .busy(busy)
   );

   fpm_mul_arbiter #(.WIDTH(32), .LATENCY(1)) dut1 (
      .clk(clk), .rst(rst),
      .req0_valid(d1_req0_valid), .req0_a(d1_req0_a), .req0_b(d1_req0_b), .req0_ready(d1_req0_ready),
      .req1_valid(d1_req1_valid), .req1_a(d1_req1_a), .req1_b(d1_req1_b), .req1_ready(d1_req1_ready),
      .mul_a(d1_mul_a), .mul_b(d1_mul_b), .mul_ce(d1_mul_ce), .mul_y(d1_mul_y),
      .res_ready(d1_res_ready), .res_valid(d1_res_valid), .res_id(d1_res_id), .res_y(d1_res_y),
      .busy(d1_busy)
   );

   // Truncating single-precision multiply for normal operands.
   function automatic logic [31:0] fmul(input logic [31:0] a, input logic [31:0] b);
      logic        s;
      int          e;
      logic [47:0] m;
      s = a[31] ^ b[31];
      if (a[30:23] == 8'd0 || b[30:23] == 8'd0) return {s, 31'd0};
      m = {24'd0, 1'b1, a[22:0]} * {24'd0, 1'b1, b[22:0]};
      e = int'(a[30:23]) + int'(b[30:23]) - 127;
      if (m[47]) begin
         e = e + 1;
         m = m >> 1;
      end
      if (e <= 0) return {s, 31'd0};
      if (e >= 255) return {s, 8'hff, 23'd0};
      return {s, e[7:0], m[45:23]};
   endfunction

   // Multiplier models: LATENCY stages, all enabled by mul_ce.
   logic [31:0] m0_st [4];
   always @(posedge clk) begin
      if (mul_ce) begin
         m0_st[0] <= fmul(mul_a, mul_b);
         for (int i = 1; i < 4; i++) m0_st[i] <= m0_st[i-1];
      end
   end
   assign mul_y = m0_st[3];

   logic [31:0] m1_st;
   always @(posedge clk) begin
      if (d1_mul_ce) m1_st <= fmul(d1_mul_a, d1_mul_b);
   end
   assign d1_mul_y = m1_st;

   int n_vec = 0;
   int n_err = 0;
   int n_pop = 0;

   task automatic cmp(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h, expected %h", nm, act, exp);
      end
   endtask

   // Reference model: grant order queue of (owner, product), last winner.
   logic        q_id [$];
   logic [31:0] q_y  [$];
   logic        m_last = 1'b1;
   logic        prev_stall = 1'b0;
   logic        prev_id;
   logic [31:0] prev_y;

   task automatic sb_check();
      logic exp_ce, gv, gid;
      if (rst) begin
         q_id.delete();
         q_y.delete();
         m_last     = 1'b1;
         prev_stall = 1'b0;
         return;
      end
      exp_ce = !(res_valid && !res_ready);
      cmp("mul_ce", mul_ce, exp_ce);
      gv  = exp_ce && (req0_valid || req1_valid);
      gid = (req0_valid && req1_valid) ? !m_last : req1_valid;
      cmp("req0_ready", req0_ready, gv && !gid);
      cmp("req1_ready", req1_ready, gv && gid);
      cmp("busy", busy, q_id.size() != 0);
      if (prev_stall) begin
         cmp("held_valid", res_valid, 1);
         cmp("held_id", res_id, prev_id);
         cmp("held_y", res_y, prev_y);
      end
      if (res_valid && q_id.size() == 0) begin
         n_vec++;
         n_err++;
         $display("FAIL res_extra: got res_valid=1, expected no result pending");
      end else if (res_valid && res_ready) begin
         cmp("res_id", res_id, q_id.pop_front());
         cmp("res_y", res_y, q_y.pop_front());
         n_pop++;
      end
      prev_stall = res_valid && !res_ready;
      prev_id    = res_id;
      prev_y     = res_y;
      if (gv) begin
         q_id.push_back(gid);
         q_y.push_back(gid ? fmul(req1_a, req1_b) : fmul(req0_a, req0_b));
         m_last = gid;
      end
   endtask

   task automatic mid();
      @(negedge clk);
      sb_check();
   endtask

   task automatic adv();
      @(posedge clk);
      #1;
   endtask

   task automatic drain(input string nm);
      req0_valid = 1'b0;
      req1_valid = 1'b0;
      res_ready  = 1'b1;
      for (int k = 0; k < 30; k++) begin
         mid();
         if (q_id.size() == 0 && !busy) break;
         adv();
      end
      cmp({nm, "_busy"}, busy, 0);
      cmp({nm, "_left"}, q_id.size(), 0);
      adv();
   endtask

   typedef struct {
      logic        r0v, r1v, rr;
      logic [31:0] a0, b0, a1, b1;
      logic        e_r0, e_r1, e_rv, e_rid, chk_y;
      logic [31:0] e_y;
   } vec_t;

   vec_t        tbl [20];
   logic [31:0] opa [4];
   logic [31:0] opb [4];
   int          base;

   initial begin
      // Directed table: single req0 op, then 8 cycles of both requesters.
      for (int r = 0; r < 20; r++) begin
         tbl[r] = '{r0v:1'b0, r1v:1'b0, rr:1'b1, a0:32'h0, b0:32'h0, a1:32'h0, b1:32'h0,
                    e_r0:1'b0, e_r1:1'b0, e_rv:1'b0, e_rid:1'b0, chk_y:1'b0, e_y:32'h0};
         if (r >= 6 && r <= 13) begin
            tbl[r].r0v  = 1'b1;
            tbl[r].r1v  = 1'b1;
            tbl[r].a0   = 32'h40400000 + (r << 18);
            tbl[r].b0   = 32'h3fc00000 + r;
            tbl[r].a1   = 32'hc0a00000 + (r << 17);
            tbl[r].b1   = 32'h41200000 + (r << 4);
            tbl[r].e_r0 = (r % 2 == 1);
            tbl[r].e_r1 = (r % 2 == 0);
         end
         if (r >= 11 && r <= 18) begin
            tbl[r].e_rv  = 1'b1;
            tbl[r].e_rid = ((r - 5) % 2 == 0);
         end
      end
      tbl[0].r0v   = 1'b1;
      tbl[0].a0    = 32'h3f800000;
      tbl[0].b0    = 32'h40000000;
      tbl[0].e_r0  = 1'b1;
      tbl[5].e_rv  = 1'b1;
      tbl[5].e_rid = 1'b0;
      tbl[5].chk_y = 1'b1;
      tbl[5].e_y   = 32'h40000000;

      rst = 1'b1;
      req0_valid = 1'b1; req1_valid = 1'b1;
      req0_a = 32'h0; req0_b = 32'h0; req1_a = 32'h0; req1_b = 32'h0;
      res_ready = 1'b1;
      d1_req0_valid = 1'b0; d1_req1_valid = 1'b0;
      d1_req0_a = 32'h0; d1_req0_b = 32'h0; d1_req1_a = 32'h0; d1_req1_b = 32'h0;
      d1_res_ready = 1'b1;

      // Reset state
      adv();
      mid();
      cmp("rst_req0_ready", req0_ready, 0);
      cmp("rst_req1_ready", req1_ready, 0);
      cmp("rst_mul_a", mul_a, 0);
      cmp("rst_mul_b", mul_b, 0);
      cmp("rst_res_valid", res_valid, 0);
      cmp("rst_busy", busy, 0);
      cmp("rst_mul_ce", mul_ce, 1);
      adv();
      rst = 1'b0;

      foreach (tbl[r]) begin
         req0_valid = tbl[r].r0v; req1_valid = tbl[r].r1v; res_ready = tbl[r].rr;
         req0_a = tbl[r].a0; req0_b = tbl[r].b0; req1_a = tbl[r].a1; req1_b = tbl[r].b1;
         mid();
         cmp($sformatf("t%0d_req0_ready", r), req0_ready, tbl[r].e_r0);
         cmp($sformatf("t%0d_req1_ready", r), req1_ready, tbl[r].e_r1);
         cmp($sformatf("t%0d_res_valid", r), res_valid, tbl[r].e_rv);
         if (tbl[r].e_rv) cmp($sformatf("t%0d_res_id", r), res_id, tbl[r].e_rid);
         if (tbl[r].chk_y) cmp($sformatf("t%0d_res_y", r), res_y, tbl[r].e_y);
         adv();
      end
      drain("tbl");

      // Full pipe blocked for 3 cycles, then released.
      base = n_pop;
      for (int k = 0; k < 8; k++) begin
         req0_valid = 1'b1; req1_valid = 1'b0; res_ready = 1'b0;
         req0_a = 32'h3f800000 + (k << 19); req0_b = 32'h40400000 + k;
         mid();
         if (k >= 5) begin
            cmp("stall_ce", mul_ce, 0);
            cmp("stall_req0_ready", req0_ready, 0);
            cmp("stall_res_valid", res_valid, 1);
         end
         adv();
      end
      drain("stall");
      cmp("stall_results", n_pop - base, 5);

      // Sparse issue: bubbles never stall even with res_ready low.
      for (int k = 0; k < 11; k++) begin
         req0_valid = (k == 0 || k == 3); req1_valid = 1'b0;
         req0_a = 32'h41000000 + k; req0_b = 32'hbf800000;
         res_ready = (k >= 5);
         mid();
         if (k < 5) cmp("sparse_ce", mul_ce, 1);
         if (k >= 5) cmp($sformatf("sparse_valid_%0d", k), res_valid, (k == 5 || k == 8));
         adv();
      end
      drain("sparse");

      // Reset with three ops in flight.
      req0_valid = 1'b1; req1_valid = 1'b1; res_ready = 1'b1;
      repeat (3) begin
         mid();
         adv();
      end
      rst = 1'b1; req0_valid = 1'b0; req1_valid = 1'b0;
      mid();
      adv();
      rst = 1'b0; req0_valid = 1'b1; req1_valid = 1'b1;
      mid();
      cmp("post_rst_busy", busy, 0);
      cmp("post_rst_res_valid", res_valid, 0);
      cmp("post_rst_tie_req0", req0_ready, 1);
      cmp("post_rst_tie_req1", req1_ready, 0);
      adv();
      drain("rst");

      // Randomized traffic against the reference model.
      for (int k = 0; k < 400; k++) begin
         req0_valid = ($urandom % 4) != 0;
         req1_valid = ($urandom % 3) != 0;
         res_ready  = ($urandom % 3) != 0;
         req0_a = $urandom; req0_b = $urandom;
         req1_a = $urandom; req1_b = $urandom;
         mid();
         adv();
      end
      drain("rand");

      // LATENCY=1 build: back-to-back requester 1.
      for (int k = 0; k < 4; k++) begin
         opa[k] = 32'h3f800000 + ($urandom % 32'h007fffff);
         opb[k] = 32'h40000000 + ($urandom % 32'h007fffff);
      end
      for (int k = 0; k < 7; k++) begin
         d1_req1_valid = (k < 4);
         d1_req1_a = opa[k % 4];
         d1_req1_b = opb[k % 4];
         mid();
         cmp($sformatf("l1_req1_ready_%0d", k), d1_req1_ready, (k < 4));
         cmp($sformatf("l1_res_valid_%0d", k), d1_res_valid, (k >= 2 && k < 6));
         cmp($sformatf("l1_mul_ce_%0d", k), d1_mul_ce, 1);
         if (k >= 2 && k < 6) begin
            cmp($sformatf("l1_res_id_%0d", k), d1_res_id, 1);
            cmp($sformatf("l1_res_y_%0d", k), d1_res_y, fmul(opa[k-2], opb[k-2]));
         end
         adv();
      end
      mid();
      cmp("l1_busy_end", d1_busy, 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
`default_nettype wire
